bf: RTL and testbench

- Self-contained Brainfuck processor: one control core plus one unified 64 KiB byte memory.
- The memory holds the program from address 0x0000 upward and the data tape from DATA_BASE upward.
- It executes ASCII Brainfuck source, takes ',' input from a byte port and drives '.' output on a byte port.
- It halts on a 0x00 program byte or on an unbalanced bracket.

---
 rtl/bf.sv | 229 ++++++++++++++++++++++
 tb/tb_bf.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf.sv
// bf: self-contained Brainfuck processor, a control core plus one unified byte memory.
// The program lives from address 0 upward and the data tape from DATA_BASE upward.

module bf_ram #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);
    logic [7:0] data [0:(1<<ADDR_W)-1];
    logic [7:0] rdata_q;

    // Single port with a registered read; contents survive reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) data[addr] <= wdata;
            rdata_q <= data[addr];
        end
    end

    assign rdata = rdata_q;
endmodule

module bf_core #(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] DATA_BASE = 'h0100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [7:0]        input_data,
    input  logic [7:0]        rdata,
    output logic [ADDR_W-1:0] addr,
    output logic              we,
    output logic [7:0]        wdata,
    output logic [7:0]        output_data,
    output logic              output_valid
);
    typedef enum logic [4:0] {
        S0, S1, S2, S3, S4, S5, S6, S7, S8, S9, S10, S11,
        S12, S13, S14, S15, S16, S17, S18, S19, S20, S21, S22, S23
    } state_t;

    localparam logic [ADDR_W-1:0] ONE = 1;

    state_t            state_c, state_d;
    logic [ADDR_W-1:0] pc, pc_d;
    logic [ADDR_W-1:0] ptr, ptr_d;
    logic [ADDR_W-1:0] depth_q, depth_d;
    logic [7:0]        instr_q, instr_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;

    state_t            step_state, fwd_state;
    logic [ADDR_W-1:0] fwd_depth, bwd_depth;

    // Advancing pc past the last address is treated as running off the program.
    assign step_state = (&pc) ? S23 : S1;
    assign fwd_state  = (&pc) ? S23 : S14;
    assign fwd_depth  = (rdata == 8'h5B) ? depth_q + ONE :
                        (rdata == 8'h5D) ? depth_q - ONE : depth_q;
    assign bwd_depth  = (rdata == 8'h5D) ? depth_q + ONE :
                        (rdata == 8'h5B) ? depth_q - ONE : depth_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_c     <= S0;
            pc          <= '0;
            ptr         <= DATA_BASE;
            depth_q     <= '0;
            instr_q     <= 8'h00;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
        end else if (en) begin
            state_c     <= state_d;
            pc          <= pc_d;
            ptr         <= ptr_d;
            depth_q     <= depth_d;
            instr_q     <= instr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_c;
        pc_d        = pc;
        ptr_d       = ptr;
        depth_d     = depth_q;
        instr_d     = instr_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        addr        = ptr;
        we          = 1'b0;
        wdata       = 8'h00;

        case (state_c)
            S0: state_d = S1;
            S1: begin addr = pc; state_d = S2; end
            S2: begin instr_d = rdata; state_d = S3; end
            S3: begin
                case (instr_q)
                    8'h3E:   state_d = S4;
                    8'h3C:   state_d = S5;
                    8'h2B:   state_d = S6;
                    8'h2D:   state_d = S8;
                    8'h2E:   state_d = S10;
                    8'h2C:   state_d = S20;
                    8'h5B:   state_d = S12;
                    8'h5D:   state_d = S16;
                    8'h00:   state_d = S23;
                    default: state_d = S21;
                endcase
            end
            S4: begin ptr_d = ptr + ONE; pc_d = pc + ONE; state_d = step_state; end
            S5: begin ptr_d = ptr - ONE; pc_d = pc + ONE; state_d = step_state; end
            S6: state_d = S7;
            S7: begin
                we = 1'b1; wdata = rdata + 8'd1; pc_d = pc + ONE; state_d = step_state;
            end
            S8: state_d = S9;
            S9: begin
                we = 1'b1; wdata = rdata - 8'd1; pc_d = pc + ONE; state_d = step_state;
            end
            S10: state_d = S11;
            S11: begin
                out_data_d = rdata; out_valid_d = 1'b1; pc_d = pc + ONE; state_d = step_state;
            end
            S12: state_d = S13;
            S13: begin
                pc_d = pc + ONE;
                if (rdata != 8'h00) begin
                    state_d = step_state;
                end else begin
                    depth_d = ONE;
                    state_d = fwd_state;
                end
            end
            S14: begin addr = pc; state_d = S15; end
            // A terminator inside a forward scan means the '[' has no partner.
            S15: begin
                addr = pc;
                if (rdata == 8'h00) begin
                    state_d = S23;
                end else begin
                    depth_d = fwd_depth;
                    pc_d    = pc + ONE;
                    state_d = (fwd_depth == '0) ? step_state : fwd_state;
                end
            end
            S16: state_d = S17;
            S17: begin
                if (rdata == 8'h00) begin
                    pc_d = pc + ONE; state_d = step_state;
                end else if (pc == '0) begin
                    state_d = S23;
                end else begin
                    depth_d = ONE; pc_d = pc - ONE; state_d = S18;
                end
            end
            S18: begin addr = pc; state_d = S19; end
            S19: begin
                addr    = pc;
                depth_d = bwd_depth;
                if (bwd_depth == '0) begin
                    pc_d = pc + ONE; state_d = step_state;
                end else if (pc == '0) begin
                    state_d = S23;
                end else begin
                    pc_d = pc - ONE; state_d = S18;
                end
            end
            S20: begin
                we = 1'b1; wdata = input_data; pc_d = pc + ONE; state_d = step_state;
            end
            S21: begin pc_d = pc + ONE; state_d = step_state; end
            S22: state_d = S23;
            S23: state_d = S23;
            default: state_d = S23;
        endcase
    end

    assign output_data  = out_data_q;
    assign output_valid = out_valid_q;
endmodule

module bf #(
    parameter int                ADDR_W        = 16,
    parameter logic [ADDR_W-1:0] DATA_BASE     = 'h0100,
    parameter string             MEM_INIT_FILE = ""
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] input_data,
    output logic [7:0] output_data,
    output logic       output_valid
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    bf_core #(.ADDR_W(ADDR_W), .DATA_BASE(DATA_BASE)) core (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .input_data   (input_data),
        .rdata        (mem_rdata),
        .addr         (mem_addr),
        .we           (mem_we),
        .wdata        (mem_wdata),
        .output_data  (output_data),
        .output_valid (output_valid)
    );

    bf_ram #(.ADDR_W(ADDR_W)) ram (
        .clk   (clk),
        .en    (en),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );
endmodule

// File: tb/tb_bf.sv
// tb_bf: directed and randomized Brainfuck programs checked against an interpreter model.
module tb_bf;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] input_data;
    logic [7:0] output_data;
    logic       output_valid;
    logic       en_at_edge = 1'b0;

    int assert_count = 0;
    int fail_count   = 0;

    logic [7:0] prog_q[$];
    logic [7:0] in_q[$];
    logic [7:0] model_in[$];
    logic [7:0] exp_out[$];
    logic [7:0] dut_out[$];
    logic [7:0] tape [0:255];

    bf #(.ADDR_W(16), .DATA_BASE(16'h0100), .MEM_INIT_FILE("")) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .input_data   (input_data),
        .output_data  (output_data),
        .output_valid (output_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) en_at_edge <= en;

    always @(negedge clk) begin
        if (rst_n && output_valid && en_at_edge) dut_out.push_back(output_data);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] out_at(input int i);
        return (i < dut_out.size()) ? 32'(dut_out[i]) : 32'hDEAD;
    endfunction

    task automatic set_prog(input string s);
        prog_q.delete();
        for (int i = 0; i < s.len(); i++) prog_q.push_back(s[i]);
    endtask

    // Plain Brainfuck interpreter over a zeroed tape; unmatched brackets halt.
    task automatic run_model();
        int pc = 0;
        int p = 0;
        int d;
        int j;
        int steps = 0;
        bit done = 0;
        logic [7:0] q[$];
        q = model_in;
        exp_out.delete();
        for (int i = 0; i < 256; i++) tape[i] = 8'h00;
        while (!done && steps < 200000) begin
            logic [7:0] c;
            steps++;
            c = (pc < prog_q.size()) ? prog_q[pc] : 8'h00;
            case (c)
                8'h00: done = 1;
                ">": p++;
                "<": p--;
                "+": tape[p] = tape[p] + 8'd1;
                "-": tape[p] = tape[p] - 8'd1;
                ".": exp_out.push_back(tape[p]);
                ",": tape[p] = (q.size() != 0) ? q.pop_front() : 8'h00;
                "[": if (tape[p] == 8'h00) begin
                    d = 1; j = pc;
                    while (d != 0) begin
                        j++;
                        if (j >= prog_q.size()) break;
                        if (prog_q[j] == "[") d++;
                        else if (prog_q[j] == "]") d--;
                    end
                    if (d != 0) done = 1; else pc = j;
                end
                "]": if (tape[p] != 8'h00) begin
                    d = 1; j = pc;
                    while (d != 0 && j > 0) begin
                        j--;
                        if (prog_q[j] == "]") d++;
                        else if (prog_q[j] == "[") d--;
                    end
                    if (d != 0) done = 1; else pc = j;
                end
                default: ;
            endcase
            if (!done) pc++;
        end
    endtask

    task automatic load_program();
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b0;
        input_data = 8'h00;
        for (int a = 0; a < 16'h0200; a++) dut.ram.data[a] = 8'h00;
        for (int i = 0; i < prog_q.size(); i++) dut.ram.data[i] = prog_q[i];
        dut_out.delete();
        run_model();
    endtask

    task automatic applyStimulus(input string tag, input int max_cycles, input int pause_at, input int reset_after);
        int cycles = 0;
        logic [31:0] pc_snap;
        logic [31:0] st_snap;
        int nout_snap;
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        while (cycles < max_cycles && dut.core.state_c != 5'd23) begin
            @(negedge clk);
            cycles++;
            if (dut.core.state_c == 5'd20) input_data = (in_q.size() != 0) ? in_q.pop_front() : 8'h00;
            if (cycles == pause_at) begin
                pc_snap   = 32'(dut.core.pc);
                st_snap   = 32'(dut.core.state_c);
                nout_snap = dut_out.size();
                en = 1'b0;
                repeat (10) @(negedge clk);
                checkOutput({tag, "_frz_pc"}, 32'(dut.core.pc), pc_snap);
                checkOutput({tag, "_frz_state"}, 32'(dut.core.state_c), st_snap);
                checkOutput({tag, "_frz_nout"}, dut_out.size(), nout_snap);
                en = 1'b1;
            end
            if (reset_after > 0 && dut_out.size() >= reset_after) begin
                for (int i = 0; i < reset_after; i++)
                    checkOutput($sformatf("%s_pre_out%0d", tag, i), out_at(i), exp_out[i]);
                #2;
                rst_n = 1'b0;
                #1;
                checkOutput({tag, "_rst_out"}, output_data, 8'h00);
                checkOutput({tag, "_rst_valid"}, output_valid, 1'b0);
                checkOutput({tag, "_rst_state"}, 32'(dut.core.state_c), 0);
                checkOutput({tag, "_rst_pc"}, 32'(dut.core.pc), 0);
                return;
            end
        end
    endtask

    task automatic compare_results(input string tag);
        checkOutput({tag, "_halt"}, 32'(dut.core.state_c), 23);
        checkOutput({tag, "_nout"}, dut_out.size(), exp_out.size());
        for (int i = 0; i < exp_out.size(); i++)
            checkOutput($sformatf("%s_out%0d", tag, i), out_at(i), exp_out[i]);
        for (int i = 0; i < 16; i++)
            checkOutput($sformatf("%s_cell%0d", tag, i), dut.ram.data[16'h0100 + i], tape[i]);
    endtask

    task automatic gen_random_program();
        int off = 0;
        int len;
        bit used_loop = 0;
        len = $urandom_range(15, 35);
        prog_q.delete(); in_q.delete(); model_in.delete();
        for (int i = 0; i < len; i++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 99);
            if (r < 25) prog_q.push_back("+");
            else if (r < 45) prog_q.push_back("-");
            else if (r < 58) begin
                if (off < 12) begin prog_q.push_back(">"); off++; end
            end else if (r < 68) begin
                if (off > 0) begin prog_q.push_back("<"); off--; end
            end else if (r < 80) prog_q.push_back(".");
            else if (r < 88) begin
                b = 8'($urandom);
                prog_q.push_back(",");
                in_q.push_back(b);
                model_in.push_back(b);
            end else if (r < 93) prog_q.push_back("a");
            else if (!used_loop) begin
                used_loop = 1;
                if (off < 12 && r[0]) begin
                    prog_q.push_back("["); prog_q.push_back(">"); prog_q.push_back("+");
                    prog_q.push_back("<"); prog_q.push_back("-"); prog_q.push_back("]");
                end else begin
                    prog_q.push_back("["); prog_q.push_back("-"); prog_q.push_back("]");
                end
            end
        end
        prog_q.push_back(".");
    endtask

    initial begin
        string hw;
        string hw_exp;
        hw     = "++++++++[>++++[>++>+++>+++>+<<<<-]>+>+>->>+[<]<-]>>.>---.+++++++..+++.>>.<-.<.+++.------.--------.>>+.>++.";
        hw_exp = "Hello World!\n";
        rst_n = 1'b0;
        en    = 1'b0;
        input_data = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_pc", 32'(dut.core.pc), 0);
        checkOutput("rst_ptr", 32'(dut.core.ptr), 32'h0100);
        checkOutput("rst_state", 32'(dut.core.state_c), 0);
        checkOutput("rst_depth", 32'(dut.core.depth_q), 0);
        checkOutput("rst_out", output_data, 8'h00);
        checkOutput("rst_valid", output_valid, 1'b0);

        set_prog("+++."); load_program();
        applyStimulus("p1", 2000, -1, 0);
        compare_results("p1");
        checkOutput("p1_lit_out", out_at(0), 8'h03);
        checkOutput("p1_lit_n", dut_out.size(), 1);
        checkOutput("p1_lit_cell", dut.ram.data[16'h0100], 8'h03);

        set_prog("-.>+.<."); load_program();
        applyStimulus("p2", 2000, -1, 0);
        compare_results("p2");
        checkOutput("p2_lit0", out_at(0), 8'hFF);
        checkOutput("p2_lit1", out_at(1), 8'h01);
        checkOutput("p2_lit2", out_at(2), 8'hFF);

        set_prog(",."); in_q = '{8'h41}; model_in = '{8'h41}; load_program();
        applyStimulus("p3", 2000, -1, 0);
        compare_results("p3");
        checkOutput("p3_lit_out", out_at(0), 8'h41);
        checkOutput("p3_lit_cell", dut.ram.data[16'h0100], 8'h41);
        in_q.delete(); model_in.delete();

        set_prog("[+.]++."); load_program();
        applyStimulus("p4", 2000, -1, 0);
        compare_results("p4");
        checkOutput("p4_lit_out", out_at(0), 8'h02);
        checkOutput("p4_lit_n", dut_out.size(), 1);

        set_prog("++++[>++<-]>."); load_program();
        applyStimulus("p5", 4000, -1, 0);
        compare_results("p5");
        checkOutput("p5_lit_out", out_at(0), 8'h08);
        checkOutput("p5_lit_c0", dut.ram.data[16'h0100], 8'h00);
        checkOutput("p5_lit_c1", dut.ram.data[16'h0101], 8'h08);

        set_prog("+]"); load_program();
        applyStimulus("ub1", 2000, -1, 0);
        repeat (20) @(negedge clk);
        compare_results("ub1");

        set_prog("[+."); load_program();
        applyStimulus("ub2", 2000, -1, 0);
        repeat (20) @(negedge clk);
        compare_results("ub2");

        for (int t = 0; t < 4; t++) begin
            gen_random_program(); load_program();
            applyStimulus($sformatf("rnd%0d", t), 15000, -1, 0);
            compare_results($sformatf("rnd%0d", t));
        end

        set_prog(hw); load_program();
        applyStimulus("hw", 20000, 400, 0);
        compare_results("hw");
        for (int i = 0; i < hw_exp.len(); i++)
            checkOutput($sformatf("hw_lit%0d", i), out_at(i), 32'(hw_exp[i]));

        set_prog(hw); load_program();
        applyStimulus("hwr", 20000, -1, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule
